// File: rtl/regfile_access_sequencer_if.sv
// Command, response and register-file port bundle of the register-file access sequencer.
// The sequencer connects through the master modport; optional carry output exists only with RFSEQ_CARRY_EN.
interface regfile_access_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              i_cmdValid;
    logic              o_cmdReady;
    logic [1:0]        i_cmdOp;
    logic [ADDR_W-1:0] i_cmdSrc1;
    logic [ADDR_W-1:0] i_cmdSrc2;
    logic [ADDR_W-1:0] i_cmdDst;

    logic [ADDR_W-1:0] o_readAdd1;
    logic [ADDR_W-1:0] o_readAdd2;
    logic              o_readEn1;
    logic              o_readEn2;
    logic [DATA_W-1:0] i_readData1;
    logic [DATA_W-1:0] i_readData2;

    logic [ADDR_W-1:0] o_writeAdd;
    logic [DATA_W-1:0] o_writeData;
    logic              o_writeEn;

    logic              o_rspValid;
    logic              i_rspReady;
    logic [DATA_W-1:0] o_rspData;
`ifdef RFSEQ_CARRY_EN
    logic              o_rspCarry;
`endif

    modport master (
        input  i_cmdValid, i_cmdOp, i_cmdSrc1, i_cmdSrc2, i_cmdDst,
        input  i_readData1, i_readData2, i_rspReady,
        output o_cmdReady, o_readAdd1, o_readAdd2, o_readEn1, o_readEn2,
        output o_writeAdd, o_writeData, o_writeEn, o_rspValid, o_rspData
`ifdef RFSEQ_CARRY_EN
        , output o_rspCarry
`endif
    );

    modport slave (
        output i_cmdValid, i_cmdOp, i_cmdSrc1, i_cmdSrc2, i_cmdDst,
        output i_readData1, i_readData2, i_rspReady,
        input  o_cmdReady, o_readAdd1, o_readAdd2, o_readEn1, o_readEn2,
        input  o_writeAdd, o_writeData, o_writeEn, o_rspValid, o_rspData
`ifdef RFSEQ_CARRY_EN
        , input o_rspCarry
`endif
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Sequences one read/compute/write/respond operation at a time against a 2R1W register file.
// Optional feature macro RFSEQ_CARRY_EN adds o_rspCarry (ADD carry-out).
module regfile_access_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    regfile_access_sequencer_if.master    bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_XOR    = 2'b01;
    localparam logic [1:0] OP_POPCNT = 2'b10;
    localparam logic [1:0] OP_MOVE   = 2'b11;

    logic [2:0]        state;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] execResult;
    logic [DATA_W-1:0] operand2;
    logic [DATA_W-1:0] sum;
    logic              useSrc2;

    function automatic logic [DATA_W-1:0] popCount(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {{(DATA_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    assign useSrc2  = (op == OP_ADD) || (op == OP_XOR);
    assign operand2 = useSrc2 ? bus.i_readData2 : '0;

`ifdef RFSEQ_CARRY_EN
    logic              carry;
    logic [DATA_W:0]   sumWide;
    assign sumWide = {1'b0, bus.i_readData1} + {1'b0, operand2};
    assign sum     = sumWide[DATA_W-1:0];
`else
    assign sum = bus.i_readData1 + operand2;
`endif

    always_comb begin
        execResult = '0;
        case (op)
            OP_ADD:    execResult = sum;
            OP_XOR:    execResult = bus.i_readData1 ^ operand2;
            OP_POPCNT: execResult = popCount(bus.i_readData1);
            OP_MOVE:   execResult = bus.i_readData1;
            default:   execResult = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            op     <= OP_ADD;
            src1   <= '0;
            src2   <= '0;
            dst    <= '0;
            result <= '0;
`ifdef RFSEQ_CARRY_EN
            carry  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_cmdValid) begin
                        op    <= bus.i_cmdOp;
                        src1  <= bus.i_cmdSrc1;
                        src2  <= bus.i_cmdSrc2;
                        dst   <= bus.i_cmdDst;
                        state <= READ;
                    end
                end
                READ:  state <= EXEC;
                EXEC: begin
                    result <= execResult;
`ifdef RFSEQ_CARRY_EN
                    carry  <= (op == OP_ADD) && sumWide[DATA_W];
`endif
                    state  <= WRITE;
                end
                WRITE: state <= RESP;
                RESP:  if (bus.i_rspReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: outputs are decoded from state rather than registered, so asserting
    // i_rst removes o_writeEn in the same instant and no partial write can land.
    assign bus.o_cmdReady  = (state == IDLE);
    assign bus.o_readEn1   = (state == READ);
    assign bus.o_readEn2   = (state == READ) && useSrc2;
    assign bus.o_readAdd1  = (state == READ) ? src1 : '0;
    assign bus.o_readAdd2  = (state == READ) ? src2 : '0;
    assign bus.o_writeEn   = (state == WRITE) && (dst != '0);
    assign bus.o_writeAdd  = (state == WRITE) ? dst : '0;
    assign bus.o_writeData = (state == WRITE) ? result : '0;
    assign bus.o_rspValid  = (state == RESP);
    assign bus.o_rspData   = (state == RESP) ? result : '0;
`ifdef RFSEQ_CARRY_EN
    assign bus.o_rspCarry  = (state == RESP) && carry;
`endif

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Self-checking bench: register-file model plus table-driven operations and hand-written corner sequences.
// Build with +define+RFSEQ_CARRY_EN to also check o_rspCarry.
module tb_regfile_access_sequencer;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_XOR    = 2'b01;
    localparam logic [1:0] OP_POPCNT = 2'b10;
    localparam logic [1:0] OP_MOVE   = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic        expEn2;
        logic        expWen;
        logic [31:0] expResult;
        logic        expCarry;
    } vec_t;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   failures;

    regfile_access_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_access_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register file model: synchronous read, enabled write, r0 reads as zero.
    logic [31:0] rf [32];
    logic        rfClear;
    logic        ldEn;
    logic [4:0]  ldAddr;
    logic [31:0] ldData;

    always @(posedge i_clk) begin
        if (rfClear) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (ldEn) begin
            rf[ldAddr] <= ldData;
        end else if (bus.o_writeEn && bus.o_writeAdd != 5'd0) begin
            rf[bus.o_writeAdd] <= bus.o_writeData;
        end
        if (bus.o_readEn1) bus.i_readData1 <= (bus.o_readAdd1 == 5'd0) ? 32'd0 : rf[bus.o_readAdd1];
        if (bus.o_readEn2) bus.i_readData2 <= (bus.o_readAdd2 == 5'd0) ? 32'd0 : rf[bus.o_readAdd2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rfLoad(input logic [4:0] a, input logic [31:0] d);
        ldEn   = 1'b1;
        ldAddr = a;
        ldData = d;
        @(negedge i_clk);
        ldEn   = 1'b0;
    endtask

    // Entered and left at a falling edge with the sequencer idle.
    task automatic runOp(input vec_t v, input int stall, input string tag);
        check($sformatf("%s cmdReady idle", tag), 32'(bus.o_cmdReady), 32'd1);
        bus.i_cmdValid = 1'b1;
        bus.i_cmdOp    = v.op;
        bus.i_cmdSrc1  = v.src1;
        bus.i_cmdSrc2  = v.src2;
        bus.i_cmdDst   = v.dst;
        bus.i_rspReady = (stall == 0);
        @(negedge i_clk);
        bus.i_cmdValid = 1'b0;
        check($sformatf("%s READ readEn1", tag), 32'(bus.o_readEn1), 32'd1);
        check($sformatf("%s READ readEn2", tag), 32'(bus.o_readEn2), 32'(v.expEn2));
        check($sformatf("%s READ readAdd1", tag), 32'(bus.o_readAdd1), 32'(v.src1));
        check($sformatf("%s READ readAdd2", tag), 32'(bus.o_readAdd2), 32'(v.src2));
        check($sformatf("%s READ cmdReady", tag), 32'(bus.o_cmdReady), 32'd0);
        @(negedge i_clk);
        check($sformatf("%s EXEC readEn1", tag), 32'(bus.o_readEn1), 32'd0);
        check($sformatf("%s EXEC writeEn", tag), 32'(bus.o_writeEn), 32'd0);
        check($sformatf("%s EXEC rspValid", tag), 32'(bus.o_rspValid), 32'd0);
        @(negedge i_clk);
        check($sformatf("%s WRITE writeEn", tag), 32'(bus.o_writeEn), 32'(v.expWen));
        check($sformatf("%s WRITE writeAdd", tag), 32'(bus.o_writeAdd), 32'(v.dst));
        check($sformatf("%s WRITE writeData", tag), bus.o_writeData, v.expResult);
        check($sformatf("%s WRITE rspValid", tag), 32'(bus.o_rspValid), 32'd0);
        @(negedge i_clk);
        check($sformatf("%s RESP rspValid", tag), 32'(bus.o_rspValid), 32'd1);
        check($sformatf("%s RESP rspData", tag), bus.o_rspData, v.expResult);
        check($sformatf("%s RESP writeEn", tag), 32'(bus.o_writeEn), 32'd0);
`ifdef RFSEQ_CARRY_EN
        check($sformatf("%s RESP rspCarry", tag), 32'(bus.o_rspCarry), 32'(v.expCarry));
`endif
        if (stall > 0) begin
            // A competing command held during the stall must be ignored.
            bus.i_cmdValid = 1'b1;
            bus.i_cmdOp    = OP_MOVE;
            bus.i_cmdSrc1  = 5'd1;
            bus.i_cmdDst   = 5'd20;
            for (int i = 0; i < stall; i++) begin
                @(negedge i_clk);
                check($sformatf("%s stall%0d rspValid", tag, i), 32'(bus.o_rspValid), 32'd1);
                check($sformatf("%s stall%0d rspData", tag, i), bus.o_rspData, v.expResult);
                check($sformatf("%s stall%0d cmdReady", tag, i), 32'(bus.o_cmdReady), 32'd0);
            end
            bus.i_cmdValid = 1'b0;
            bus.i_rspReady = 1'b1;
        end
        @(negedge i_clk);
        bus.i_rspReady = 1'b0;
        check($sformatf("%s done rspValid", tag), 32'(bus.o_rspValid), 32'd0);
        check($sformatf("%s done cmdReady", tag), 32'(bus.o_cmdReady), 32'd1);
        if (v.dst != 5'd0) check($sformatf("%s rf[dst]", tag), rf[v.dst], v.expResult);
    endtask

    vec_t vecs [7];
    vec_t v;

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{OP_ADD,    5'd1,  5'd2,  5'd4,  1'b1, 1'b1, 32'h0000_0008, 1'b0};
        vecs[1] = '{OP_MOVE,   5'd4,  5'd0,  5'd15, 1'b0, 1'b1, 32'h0000_0008, 1'b0};
        vecs[2] = '{OP_ADD,    5'd11, 5'd12, 5'd6,  1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{OP_POPCNT, 5'd7,  5'd2,  5'd8,  1'b0, 1'b1, 32'h0000_0009, 1'b0};
        vecs[4] = '{OP_MOVE,   5'd13, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0000_1234, 1'b0};
        vecs[5] = '{OP_XOR,    5'd1,  5'd2,  5'd14, 1'b1, 1'b1, 32'h0000_0006, 1'b0};
        vecs[6] = '{OP_ADD,    5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 32'h0000_0020, 1'b0};

        i_rst          = 1'b1;
        rfClear        = 1'b1;
        ldEn           = 1'b0;
        ldAddr         = '0;
        ldData         = '0;
        bus.i_cmdValid = 1'b0;
        bus.i_cmdOp    = '0;
        bus.i_cmdSrc1  = '0;
        bus.i_cmdSrc2  = '0;
        bus.i_cmdDst   = '0;
        bus.i_rspReady = 1'b0;
        repeat (2) @(negedge i_clk);

        check("reset cmdReady", 32'(bus.o_cmdReady), 32'd1);
        check("reset readEn", {30'd0, bus.o_readEn1, bus.o_readEn2}, 32'd0);
        check("reset writeEn", 32'(bus.o_writeEn), 32'd0);
        check("reset writeData", bus.o_writeData, 32'd0);
        check("reset rspValid", 32'(bus.o_rspValid), 32'd0);
        check("reset rspData", bus.o_rspData, 32'd0);
`ifdef RFSEQ_CARRY_EN
        check("reset rspCarry", 32'(bus.o_rspCarry), 32'd0);
`endif
        i_rst   = 1'b0;
        rfClear = 1'b0;

        rfLoad(5'd1,  32'h0000_0005);
        rfLoad(5'd2,  32'h0000_0003);
        rfLoad(5'd3,  32'h0000_0077);
        rfLoad(5'd5,  32'h0000_0010);
        rfLoad(5'd7,  32'hF0F0_0001);
        rfLoad(5'd9,  32'h0000_DEAD);
        rfLoad(5'd10, 32'h0000_BEEF);
        rfLoad(5'd11, 32'hFFFF_FFFF);
        rfLoad(5'd12, 32'h0000_0001);
        rfLoad(5'd13, 32'h0000_1234);

        for (int i = 0; i < 7; i++) runOp(vecs[i], 0, $sformatf("vec%0d", i));

        // Backpressure on XOR, then a dependent MOVE issued immediately.
        v = '{OP_XOR,  5'd4, 5'd4, 5'd9,  1'b1, 1'b1, 32'h0, 1'b0};
        runOp(v, 5, "xor_stall");
        v = '{OP_MOVE, 5'd9, 5'd0, 5'd10, 1'b0, 1'b1, 32'h0, 1'b0};
        runOp(v, 0, "move_dep");

        // Reset asserted during WRITE abandons the operation.
        bus.i_cmdValid = 1'b1;
        bus.i_cmdOp    = OP_ADD;
        bus.i_cmdSrc1  = 5'd1;
        bus.i_cmdSrc2  = 5'd2;
        bus.i_cmdDst   = 5'd3;
        bus.i_rspReady = 1'b1;
        @(negedge i_clk);
        bus.i_cmdValid = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_write writeEn before", 32'(bus.o_writeEn), 32'd1);
        #1 i_rst = 1'b1;
        #1;
        check("rst_write writeEn drop", 32'(bus.o_writeEn), 32'd0);
        check("rst_write rspValid", 32'(bus.o_rspValid), 32'd0);
        check("rst_write cmdReady", 32'(bus.o_cmdReady), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("rst_write no rsp", 32'(bus.o_rspValid), 32'd0);
        end
        check("rst_write r3 kept", rf[3], 32'h0000_0077);
        check("rst_write cmdReady after", 32'(bus.o_cmdReady), 32'd1);
        bus.i_rspReady = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
